// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control unit.
// Sequences one instruction at a time through fetch, decode and an execute
// path. The Illegal output flags an unsupported encoding for one cycle.
//
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   op, funct3, funct7b5     instruction fields
//   Zero, Lt, Ltu            ALU compare flags
//   mem_ready                memory access completes this cycle
//   PCWrite .. ALUControl    datapath controls
//   Illegal                  one-cycle pulse on an unsupported instruction
//
// state    | meaning
// ---------+------------------------------------------------------
// FETCH    | read instruction, PC <= PC+4 once memory is ready
// DECODE   | read registers, compute branch target, pick path
// MEMADR   | compute load/store address
// MEMREAD  | wait for load data
// MEMWB    | write load data to register file
// MEMWRITE | hold store request until memory is ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU result to register file
// JAL      | PC <= target, compute link address
// BRANCH   | compare operands, conditionally update PC
module multicycle_controller #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int BRANCH_FULL   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       Lt,
   input  logic       Ltu,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t     state_q, state_d;
   state_t     dec_state;
   logic       dec_illegal;
   logic       mem_rdy;
   logic       taken;
   logic [2:0] alu_fn;
   logic       pc_wr, ir_wr, mem_wr, reg_wr, illegal_raw;

   assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      dec_state   = S_FETCH;
      dec_illegal = 1'b0;
      case (op)
         OP_LOAD, OP_STORE: dec_state = S_MEMADR;
         OP_R: begin
            if (funct3 inside {3'b001, 3'b011, 3'b101}) dec_illegal = 1'b1;
            else                                        dec_state   = S_EXECR;
         end
         OP_I: begin
            if (funct3 inside {3'b001, 3'b011, 3'b101}) dec_illegal = 1'b1;
            else                                        dec_state   = S_EXECI;
         end
         OP_JAL: dec_state = S_JAL;
         OP_BRANCH: begin
            if ((funct3 inside {3'b010, 3'b011}) || ((BRANCH_FULL == 0) && funct3[2]))
               dec_illegal = 1'b1;
            else
               dec_state = S_BRANCH;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // op[5] separates R-type from I-type, so addi never turns into sub.
   always_comb begin
      alu_fn = ALU_ADD;
      case (funct3)
         3'b000:  alu_fn = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_fn = ALU_SLT;
         3'b100:  alu_fn = ALU_XOR;
         3'b110:  alu_fn = ALU_OR;
         3'b111:  alu_fn = ALU_AND;
         default: alu_fn = ALU_ADD;
      endcase
   end

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = Zero;
         3'b001:  taken = ~Zero;
         3'b100:  taken = Lt;
         3'b101:  taken = ~Lt;
         3'b110:  taken = Ltu;
         3'b111:  taken = ~Ltu;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      pc_wr       = 1'b0;
      ir_wr       = 1'b0;
      mem_wr      = 1'b0;
      reg_wr      = 1'b0;
      illegal_raw = 1'b0;
      AdrSrc      = 1'b0;
      ResultSrc   = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ImmSrc      = 2'b00;
      ALUControl  = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (mem_rdy) begin
               pc_wr   = 1'b1;
               ir_wr   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA     = 2'b01;
            ALUSrcB     = 2'b01;
            ImmSrc      = 2'b10;
            illegal_raw = dec_illegal;
            state_d     = dec_state;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = op[5] ? 2'b01 : 2'b00;
            state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_rdy) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            reg_wr    = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_wr = 1'b1;
            if (mem_rdy) state_d = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_fn;
            state_d    = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_fn;
            state_d    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_wr  = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            pc_wr   = 1'b1;
            state_d = S_ALUWB;
         end
         S_BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            pc_wr      = taken;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Write enables are masked by reset so FETCH cannot commit while held.
   assign PCWrite  = pc_wr & rst_n;
   assign IRWrite  = ir_wr & rst_n;
   assign MemWrite = mem_wr & rst_n;
   assign RegWrite = reg_wr & rst_n;
   assign Illegal  = illegal_raw & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic       clk, rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero, Lt, Ltu, mem_ready;

   logic       pcw_a, irw_a, mw_a, rw_a, adr_a, ill_a;
   logic [1:0] res_a, sa_a, sb_a, imm_a;
   logic [2:0] alu_a;
   logic       pcw_b, irw_b, mw_b, rw_b, adr_b, ill_b;
   logic [1:0] res_b, sa_b, sb_b, imm_b;
   logic [2:0] alu_b;

   logic [16:0] v_a, v_b;
   assign v_a = {ill_a, pcw_a, irw_a, mw_a, rw_a, adr_a, res_a, sa_a, sb_a, imm_a, alu_a};
   assign v_b = {ill_b, pcw_b, irw_b, mw_b, rw_b, adr_b, res_b, sa_b, sb_b, imm_b, alu_b};

   multicycle_controller u_dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
      .PCWrite(pcw_a), .IRWrite(irw_a), .MemWrite(mw_a), .RegWrite(rw_a),
      .AdrSrc(adr_a), .ResultSrc(res_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a),
      .ImmSrc(imm_a), .ALUControl(alu_a), .Illegal(ill_a));

   multicycle_controller #(.MEM_HANDSHAKE(0), .BRANCH_FULL(0)) u_lite (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
      .PCWrite(pcw_b), .IRWrite(irw_b), .MemWrite(mw_b), .RegWrite(rw_b),
      .AdrSrc(adr_b), .ResultSrc(res_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b),
      .ImmSrc(imm_b), .ALUControl(alu_b), .Illegal(ill_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [16:0] exp_q[$];
   logic [16:0] obs_q[$];
   bit          mr_q[$];

   function automatic logic [16:0] pk(input logic ill, pcw, irw, mw, rw, adr,
                                      input logic [1:0] res, sa, sb, imm,
                                      input logic [2:0] alu);
      return {ill, pcw, irw, mw, rw, adr, res, sa, sb, imm, alu};
   endfunction

   // Expected per-cycle control vector for one instruction, derived from the
   // instruction-level behaviour: fetch, decode, then the class-specific path.
   task automatic build(input logic [6:0] o, input logic [2:0] f3,
                        input bit f7, z, lt, ltu, input int fw, mwt,
                        input bit full, hs, idle);
      int  k;
      bit  r, e, ill;
      int  cls;
      logic [2:0] alu;
      bit  tk;
      exp_q.delete();
      mr_q.delete();
      k = 0;
      while (1) begin
         r = (k >= fw);
         e = hs ? r : 1'b1;
         exp_q.push_back(pk(0, e, e, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0));
         mr_q.push_back(r);
         if (e) break;
         k++;
      end
      cls = 0;
      if (o == OP_LOAD) cls = 1;
      else if (o == OP_STORE) cls = 2;
      else if (o == OP_R && !(f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5)) cls = 3;
      else if (o == OP_I && !(f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5)) cls = 4;
      else if (o == OP_JAL) cls = 5;
      else if (o == OP_BRANCH && f3 != 3'd2 && f3 != 3'd3 && (full || f3 < 3'd4)) cls = 6;
      ill = (cls == 0);
      exp_q.push_back(pk(ill, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'd0));
      mr_q.push_back(1'($urandom));
      case (f3)
         3'd0: alu = (o[5] && f7) ? 3'd1 : 3'd0;
         3'd2: alu = 3'd5;
         3'd4: alu = 3'd4;
         3'd6: alu = 3'd3;
         3'd7: alu = 3'd2;
         default: alu = 3'd0;
      endcase
      case (f3)
         3'd0: tk = z;
         3'd1: tk = !z;
         3'd4: tk = lt;
         3'd5: tk = !lt;
         3'd6: tk = ltu;
         3'd7: tk = !ltu;
         default: tk = 0;
      endcase
      if (cls == 1 || cls == 2) begin
         exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01,
                            (cls == 2) ? 2'b01 : 2'b00, 3'd0));
         mr_q.push_back(1'($urandom));
         k = 0;
         while (1) begin
            r = (k >= mwt);
            e = hs ? r : 1'b1;
            exp_q.push_back(pk(0, 0, 0, cls == 2, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0));
            mr_q.push_back(r);
            if (e) break;
            k++;
         end
         if (cls == 1) begin
            exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0));
            mr_q.push_back(1'($urandom));
         end
      end else if (cls == 3 || cls == 4 || cls == 5) begin
         if (cls == 3)
            exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu));
         else if (cls == 4)
            exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu));
         else
            exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'd0));
         mr_q.push_back(1'($urandom));
         exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0));
         mr_q.push_back(1'($urandom));
      end else if (cls == 6) begin
         exp_q.push_back(pk(0, tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'd1));
         mr_q.push_back(1'($urandom));
      end
      if (idle) begin
         exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0));
         mr_q.push_back(1'b0);
      end
   endtask

   // Drives the expected mem_ready pattern and records what the DUT showed.
   task automatic run(input bit sel, input logic [6:0] o, input logic [2:0] f3,
                      input bit f7, z, lt, ltu);
      obs_q.delete();
      for (int i = 0; i < exp_q.size(); i++) begin
         #1;
         if (i == 0) begin
            op = o; funct3 = f3; funct7b5 = f7; Zero = z; Lt = lt; Ltu = ltu;
         end
         mem_ready = mr_q[i];
         @(negedge clk);
         obs_q.push_back(sel ? v_b : v_a);
         @(posedge clk);
      end
   endtask

   task automatic do_instr(input bit sel, input logic [6:0] o, input logic [2:0] f3,
                           input bit f7, z, lt, ltu, input int fw, mwt, input bit idle);
      build(o, f3, f7, z, lt, ltu, fw, mwt, !sel, !sel, idle && !sel);
      run(sel, o, f3, f7, z, lt, ltu);
   endtask

   task automatic apply_reset;
      @(posedge clk);
      #1 rst_n = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [16:0] rv;
      rv = pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0);
      rst_n = 1'b0;
      mem_ready = 1'b1;
      op = OP_R; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 0; Lt = 0; Ltu = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (v_a !== rv) $display("FAIL reset_a got=%h exp=%h", v_a, rv);
      else n_pass++;
      n_checks++;
      if (v_b !== rv) $display("FAIL reset_b got=%h exp=%h", v_b, rv);
      else n_pass++;
      #1 rst_n = 1'b1;
      mem_ready = 1'b0;
   endtask

   task automatic test_load;
      apply_reset();
      do_instr(0, OP_LOAD, 3'd2, 0, 0, 0, 0, 0, 0, 0);
      do_instr(0, OP_LOAD, 3'd2, 1, 1, 1, 1, 2, 3, 1);
      for (int i = 0; i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL load cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_load_timing;
      apply_reset();
      do_instr(0, OP_LOAD, 3'd2, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL load_timing cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_store_wait;
      apply_reset();
      do_instr(0, OP_STORE, 3'd2, 0, 0, 0, 0, 0, 2, 1);
      for (int i = 0; i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL store_wait cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_branch;
      apply_reset();
      for (int t = 0; t < 10; t++) begin
         logic [2:0] f3;
         bit z, lt, ltu;
         if (t == 0)      begin f3 = 3'd1; z = 0; lt = 0; ltu = 0; end
         else if (t == 1) begin f3 = 3'd1; z = 1; lt = 0; ltu = 0; end
         else begin
            f3 = 3'($urandom_range(4, 7));
            if (t < 4) f3 = 3'($urandom_range(0, 1));
            z = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
         end
         do_instr(0, OP_BRANCH, f3, 0, z, lt, ltu, 0, 0, t == 9);
         for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL branch t=%0d cyc=%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_alu;
      apply_reset();
      for (int t = 0; t < 12; t++) begin
         logic [6:0] o;
         logic [2:0] f3;
         bit f7;
         if (t == 0)      begin o = OP_R; f3 = 3'd0; f7 = 1; end
         else if (t == 1) begin o = OP_I; f3 = 3'd0; f7 = 1; end
         else begin
            o = t[0] ? OP_R : OP_I;
            f3 = 3'($urandom_range(0, 7));
            if (f3 == 3'd1 || f3 == 3'd3 || f3 == 3'd5) f3 = 3'd6;
            f7 = 1'($urandom);
         end
         do_instr(0, o, f3, f7, 0, 0, 0, 0, 0, 0);
         for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL alu t=%0d cyc=%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_illegal;
      apply_reset();
      for (int t = 0; t < 6; t++) begin
         logic [6:0] o;
         logic [2:0] f3;
         case (t)
            0: begin o = 7'b0000000; f3 = 3'd0; end
            1: begin o = OP_R;       f3 = 3'd1; end
            2: begin o = OP_I;       f3 = 3'd5; end
            3: begin o = OP_BRANCH;  f3 = 3'd2; end
            4: begin o = OP_BRANCH;  f3 = 3'd3; end
            default: begin o = 7'b1110011; f3 = 3'($urandom); end
         endcase
         do_instr(0, o, f3, 1, 1, 1, 1, 0, 0, 1);
         for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL illegal t=%0d cyc=%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_lite;
      apply_reset();
      for (int t = 0; t < 6; t++) begin
         logic [6:0] o;
         logic [2:0] f3;
         case (t)
            0: begin o = OP_BRANCH; f3 = 3'd6; end
            1: begin o = OP_BRANCH; f3 = 3'd0; end
            2: begin o = OP_BRANCH; f3 = 3'($urandom_range(4, 7)); end
            3: begin o = OP_LOAD;   f3 = 3'd2; end
            4: begin o = OP_STORE;  f3 = 3'd2; end
            default: begin o = OP_BRANCH; f3 = 3'd1; end
         endcase
         // Memory waits requested but ignored by the non-handshake variant.
         do_instr(1, o, f3, 0, 1'($urandom), 0, 1, 3, 3, 0);
         for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL lite t=%0d cyc=%0d got=%h exp=%h", t, i, obs_q[i], exp_q[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random;
      logic [6:0] ops [6];
      ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_R;
      ops[3] = OP_I; ops[4] = OP_JAL; ops[5] = OP_BRANCH;
      apply_reset();
      for (int t = 0; t < 40; t++) begin
         int idx;
         logic [6:0] o;
         idx = $urandom_range(0, 6);
         o = (idx == 6) ? 7'($urandom) : ops[idx];
         do_instr(0, o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
         for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL random t=%0d op=%b cyc=%0d got=%h exp=%h", t, o, i, obs_q[i], exp_q[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_memwrite;
      logic [16:0] rv, fv;
      rv = pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0);
      fv = pk(0, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0);
      apply_reset();
      build(OP_STORE, 3'd2, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      void'(exp_q.pop_back());
      void'(mr_q.pop_back());
      run(0, OP_STORE, 3'd2, 0, 0, 0, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL rst_mw_pre cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
      #1 mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mw_a !== 1'b1) $display("FAIL rst_mw_active got=%b exp=1", mw_a);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (v_a !== rv) $display("FAIL rst_mw_async got=%h exp=%h", v_a, rv);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (v_a !== fv) $display("FAIL rst_mw_fetch got=%h exp=%h", v_a, fv);
      else n_pass++;
      @(posedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; op = '0; funct3 = '0;
      funct7b5 = 1'b0; Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
      test_reset();
      test_load();
      test_load_timing();
      test_store_wait();
      test_branch();
      test_alu();
      test_illegal();
      test_lite();
      test_random();
      test_reset_memwrite();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
